// File: rtl/gear_timer_unit_pkg.sv
// Shared channel/gear codes, accel FSM state encoding and the per-channel step limit table.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package gear_timer_unit_pkg;

  typedef logic [2:0] chan_t;
  typedef logic [3:0] step_t;

  localparam chan_t CH_NONE = 3'b000;
  localparam chan_t CH1     = 3'b001;
  localparam chan_t CH2     = 3'b010;
  localparam chan_t CH3     = 3'b011;
  localparam chan_t CH4     = 3'b100;
  localparam chan_t CH5     = 3'b101;

  localparam logic [2:0] GEAR6 = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_e;

  // Codes 001..101 name a timer channel; everything else means "no channel".
  function automatic logic chan_valid(input chan_t ch);
    return (ch >= CH1) && (ch <= CH5);
  endfunction

  // Number of speed-step ticks a channel counts before its done pulse.
  // Channel 5 in sixth gear is a short single-step timer.
  function automatic step_t limit_of(input chan_t ch, input logic [2:0] va);
    step_t lim;
    lim = 4'd0;
    case (ch)
      CH1:     lim = 4'd3;
      CH2:     lim = 4'd4;
      CH3:     lim = 4'd5;
      CH4:     lim = 4'd6;
      CH5:     lim = (va == GEAR6) ? 4'd1 : 4'd7;
      default: lim = 4'd0;
    endcase
    return lim;
  endfunction

  // One-hot pulse vector {T5..T1} for a channel code.
  function automatic logic [4:0] chan_onehot(input chan_t ch);
    logic [4:0] oh;
    oh = 5'b00000;
    case (ch)
      CH1:     oh = 5'b00001;
      CH2:     oh = 5'b00010;
      CH3:     oh = 5'b00100;
      CH4:     oh = 5'b01000;
      CH5:     oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/gear_timer_unit_if.sv
// Gearbox <-> timer signal bundle: enables/gear in, done pulses and speedometer step out.
// Latency: n/a (wires only).
// Backpressure: none; the gearbox FSM holds ET/ETD level-style until it sees a done pulse.
interface gear_timer_unit_if;
  import gear_timer_unit_pkg::*;

  chan_t      ET;
  logic       EnD;
  logic       ETD;
  logic [2:0] VA;
  logic       T1;
  logic       T2;
  logic       T3;
  logic       T4;
  logic       T5;
  logic       TD;
  step_t      Vlm;
  logic       busy;

  modport master (
    output ET, EnD, ETD, VA,
    input  T1, T2, T3, T4, T5, TD, Vlm, busy
  );

  modport slave (
    input  ET, EnD, ETD, VA,
    output T1, T2, T3, T4, T5, TD, Vlm, busy
  );
endinterface

// File: rtl/gear_timer_unit_prescaler.sv
// Free-running divide-by-TICK_DIV counter producing a one-cycle tick on its last count.
// Latency: first tick TICK_DIV-1 cycles after clr drops; then every TICK_DIV cycles.
// Backpressure: none; clr holds the count at 0 and suppresses tick.
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear on request or at the wrap point, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = 8'd0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/gear_timer_unit.sv
// Gearbox timer end: per-channel accel step timers with done pulses T1..T5, plus an independent decel pulser TD.
// Latency: Tn rises LIMIT*TICK_DIV+1 cycles after the channel select is registered; TD every DEC_TICKS*TICK_DIV cycles.
// Backpressure: none; a select change mid-count silently restarts the count, dropping ETD clears the decel side.
module gear_timer_unit
  import gear_timer_unit_pkg::*;
#(
  parameter int TICK_DIV  = 10,
  parameter int DEC_TICKS = 3
) (
  input  logic             clk,
  input  logic             rst,
  gear_timer_unit_if.slave bus
);

  localparam step_t DEC_LAST = step_t'(DEC_TICKS - 1);

  chan_t      sel_q, sel_d;
  chan_t      ch_q, ch_d;
  state_e     state_q, state_d;
  step_t      step_q, step_d;
  step_t      step_inc;
  step_t      limit;
  logic [4:0] t_q, t_d;
  logic       busy_q, busy_d;
  logic       acc_clr;
  logic       acc_tick;

  step_t      dcnt_q, dcnt_d;
  logic       td_q, td_d;
  logic       dec_tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_acc_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .tick (acc_tick)
  );

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_dec_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (!bus.ETD),
    .tick (dec_tick)
  );

  // Decode the gearbox enable into a channel (or none) for registering.
  always_comb begin
    sel_d = CH_NONE;
    if (bus.EnD && chan_valid(bus.ET)) begin
      sel_d = bus.ET;
    end
  end

  assign step_inc = step_q + 4'd1;
  assign limit    = limit_of(ch_q, bus.VA);

  // Accel FSM: a select change always wins over a tick, so a switched channel never fires.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    step_d  = step_q;
    t_d     = 5'b00000;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        acc_clr = 1'b1;
        step_d  = 4'd0;
        if (sel_q != CH_NONE) begin
          state_d = COUNT;
          ch_d    = sel_q;
        end
      end
      COUNT: begin
        if (sel_q != ch_q) begin
          acc_clr = 1'b1;
          step_d  = 4'd0;
          if (sel_q == CH_NONE) begin
            state_d = IDLE;
          end else begin
            ch_d = sel_q;
          end
        end else if (acc_tick) begin
          step_d = step_inc;
          if (step_inc == limit) begin
            state_d = FIRE;
            t_d     = chan_onehot(ch_q);
          end
        end
      end
      FIRE: begin
        acc_clr = 1'b1;
        step_d  = 4'd0;
        state_d = (sel_q == ch_q) ? COUNT : IDLE;
      end
      default: begin
        acc_clr = 1'b1;
        step_d  = 4'd0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Accel state, select and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q   <= CH_NONE;
      ch_q    <= CH_NONE;
      state_q <= IDLE;
      step_q  <= 4'd0;
      t_q     <= 5'b00000;
      busy_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      ch_q    <= ch_d;
      state_q <= state_d;
      step_q  <= step_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
    end
  end

  // Decel tick counter: pulse TD on every DEC_TICKS-th tick; ETD low clears it at once.
  always_comb begin
    dcnt_d = dcnt_q;
    td_d   = 1'b0;
    if (!bus.ETD) begin
      dcnt_d = 4'd0;
    end else if (dec_tick) begin
      if (dcnt_q == DEC_LAST) begin
        dcnt_d = 4'd0;
        td_d   = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 4'd1;
      end
    end
  end

  // Decel counter and TD output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt_q <= 4'd0;
      td_q   <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      td_q   <= td_d;
    end
  end

  // Vlm is the step register itself, so it is already a registered output.
  assign bus.T1   = t_q[0];
  assign bus.T2   = t_q[1];
  assign bus.T3   = t_q[2];
  assign bus.T4   = t_q[3];
  assign bus.T5   = t_q[4];
  assign bus.TD   = td_q;
  assign bus.Vlm  = step_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_gear_timer_unit.sv
// Bench for gear_timer_unit with TICK_DIV=2, DEC_TICKS=3: directed scenarios then random segments.
// Latency: n/a.
// Backpressure: n/a.
module tb_gear_timer_unit;

  localparam int TDIV = 2;
  localparam int DTK  = 3;

  logic clk = 1'b0;
  logic rst;

  gear_timer_unit_if bus ();

  gear_timer_unit #(.TICK_DIV(TDIV), .DEC_TICKS(DTK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a "segment" is a run of edges with one effective channel.
  // Within a segment the timer is periodic with period LIMIT*TDIV+1 counted from the
  // edge the channel was registered; sh delays that by one edge when the previous
  // channel was firing exactly at the switch (it has to pass through IDLE first).
  int         cur_ch = 0;
  int         cur_n  = 0;
  int         sh     = 0;
  int         dm     = -1;
  logic [4:0] exp_t;
  logic [3:0] exp_v;
  logic       exp_b;
  logic       exp_td;
  logic [4:0] last_t;

  function automatic int lim(input int c, input logic [2:0] va);
    if (c == 5 && va == 3'b110) return 1;
    return c + 2;
  endfunction

  task automatic seg_expect(input int c, input int n, input int s, input logic [2:0] va);
    int m, per, p;
    exp_t = 5'b00000;
    exp_v = 4'd0;
    exp_b = 1'b0;
    m = n - s;
    if (c != 0 && m > 0) begin
      per   = lim(c, va) * TDIV + 1;
      p     = m % per;
      exp_b = 1'b1;
      if (p == 0) begin
        exp_t[c-1] = 1'b1;
        exp_v      = 4'(lim(c, va));
      end else begin
        exp_v = 4'((p - 1) / TDIV);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: model the edge from the inputs in force, then compare just after it.
  task automatic cyc();
    int         eff;
    logic [2:0] va;
    logic [4:0] obs_t;
    @(posedge clk);
    va  = bus.VA;
    eff = (bus.EnD && bus.ET >= 3'd1 && bus.ET <= 3'd5) ? int'(bus.ET) : 0;
    if (!rst) begin
      cur_ch = 0; cur_n = 0; sh = 0; dm = -1;
      exp_t = 5'b00000; exp_v = 4'd0; exp_b = 1'b0; exp_td = 1'b0;
    end else begin
      if (eff != cur_ch) begin
        seg_expect(cur_ch, cur_n + 1, sh, va);
        sh     = (cur_ch != 0 && eff != 0 && exp_t != 5'b00000) ? 1 : 0;
        cur_ch = eff;
        cur_n  = 0;
      end else begin
        cur_n++;
        seg_expect(cur_ch, cur_n, sh, va);
      end
      if (bus.ETD) dm++;
      else dm = -1;
      exp_td = bus.ETD && (((dm + 1) % (DTK * TDIV)) == 0);
    end
    #1;
    obs_t  = {bus.T5, bus.T4, bus.T3, bus.T2, bus.T1};
    last_t = obs_t;
    chk("T", 8'(obs_t), 8'(exp_t));
    chk("Vlm", 8'(bus.Vlm), 8'(exp_v));
    chk("busy", 8'(bus.busy), 8'(exp_b));
    chk("TD", 8'(bus.TD), 8'(exp_td));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Runs maxc+1 edges; k = edge index (0 = select registered) of the first pulse on bit_i.
  task automatic first_pulse(input int bit_i, input int maxc, output int k);
    k = -1;
    for (int i = 0; i <= maxc; i++) begin
      cyc();
      if (k < 0 && last_t[bit_i]) k = i;
    end
  endtask

  int         k;
  logic [2:0] r_et;
  logic       r_en;
  int         r_eff;
  int         r_len;
  int         prev_eff;

  initial begin
    rst     = 1'b0;
    bus.ET  = 3'b000;
    bus.EnD = 1'b0;
    bus.ETD = 1'b0;
    bus.VA  = 3'b001;
    idle(2);
    rst = 1'b1;
    idle(3);

    // Channel 1 held: Vlm 1,2,3, T1 at edge 7, then repeats.
    bus.EnD = 1'b1;
    bus.ET  = 3'b001;
    first_pulse(0, 10, k);
    chk("t1_first", 8'(k), 8'd7);
    idle(14);
    bus.ET = 3'b000;
    idle(4);

    // Channel 5 in sixth gear pulses every 3 cycles; in fifth gear at edge 15.
    bus.VA = 3'b110;
    bus.ET = 3'b101;
    idle(12);
    bus.ET = 3'b000;
    idle(4);
    bus.VA = 3'b101;
    bus.ET = 3'b101;
    first_pulse(4, 16, k);
    chk("t5_gear5", 8'(k), 8'd15);
    bus.ET = 3'b000;
    idle(4);

    // Channel 2 switched to 3 at step 2: no T2, T3 11 edges after the switch.
    bus.ET = 3'b010;
    idle(6);
    bus.ET = 3'b011;
    first_pulse(2, 12, k);
    chk("t3_switch", 8'(k), 8'd11);
    bus.ET = 3'b000;
    idle(4);

    // Decel alongside channel 3, then ETD dropped.
    bus.ETD = 1'b1;
    bus.ET  = 3'b011;
    first_pulse(2, 12, k);
    chk("t3_with_decel", 8'(k), 8'd11);
    idle(8);
    bus.ETD = 1'b0;
    cyc();
    chk("td_drop", 8'(bus.TD), 8'd0);
    bus.ET = 3'b000;
    idle(4);

    // Reset at step 4 of channel 4, held 3 cycles, then T4 13 edges after release.
    bus.ET = 3'b100;
    idle(10);
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    first_pulse(3, 14, k);
    chk("t4_after_reset", 8'(k), 8'd13);
    bus.ET = 3'b000;
    idle(4);

    // No channel selected: decode disabled, then an invalid code.
    bus.EnD = 1'b0;
    bus.ET  = 3'b011;
    idle(25);
    bus.EnD = 1'b1;
    bus.ET  = 3'b110;
    idle(25);

    // Random segments; gear only changes when entering a channel from "none".
    prev_eff = 0;
    for (int s = 0; s < 80; s++) begin
      r_et  = 3'($urandom_range(0, 7));
      r_en  = ($urandom_range(0, 5) != 0);
      r_eff = (r_en && r_et >= 3'd1 && r_et <= 3'd5) ? int'(r_et) : 0;
      if (r_eff != 0 && prev_eff == 0) begin
        bus.VA = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'($urandom_range(1, 6));
      end
      bus.ET  = r_et;
      bus.EnD = r_en;
      r_len   = $urandom_range(1, 35);
      for (int i = 0; i < r_len; i++) begin
        if ($urandom_range(0, 15) == 0) bus.ETD = ~bus.ETD;
        cyc();
      end
      prev_eff = r_eff;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
